// File: rtl/fft_rd_pkg.sv
// Shared definitions for the FFT modulus FIFO read engine: FSM state type,
// default field layout of the 73-bit FIFO word and the saturating scaler.
package fft_rd_pkg;

    // Framing state: SYNC hunts for a start-of-frame word, RUN follows the frame.
    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } rd_state_t;

    // Default geometry of the FIFO word {sof, index, modulus}.
    localparam int DEF_IDX_WIDTH  = 11;
    localparam int DEF_MOD_WIDTH  = 61;
    localparam int DEF_DATA_WIDTH = 1 + DEF_IDX_WIDTH + DEF_MOD_WIDTH;
    localparam int DEF_MAG_WIDTH  = 16;
    localparam int DEF_MAG_SHIFT  = 24;

    // Field offsets inside the default word.
    localparam int MOD_LSB = 0;
    localparam int IDX_LSB = DEF_MOD_WIDTH;
    localparam int SOF_BIT = DEF_IDX_WIDTH + DEF_MOD_WIDTH;

    // Widest modulus / magnitude the scaler handles.
    localparam int SAT_IN_W  = 128;
    localparam int SAT_OUT_W = 32;

    // min(value >> shift, 2**mag_w - 1); mag_w must not exceed SAT_OUT_W.
    function automatic logic [SAT_OUT_W-1:0] sat_shift(
        input logic [SAT_IN_W-1:0] value,
        input int                  shift,
        input int                  mag_w
    );
        logic [SAT_IN_W-1:0] shifted;
        logic [SAT_IN_W-1:0] limit;
        shifted = value >> shift;
        limit   = (SAT_IN_W'(1) << mag_w) - SAT_IN_W'(1);
        return SAT_OUT_W'((shifted > limit) ? limit : shifted);
    endfunction

endpackage

// File: rtl/fft_rd_skid.sv
// Two-entry valid/ready skid buffer. The producer only pushes when it has
// reserved space (occupancy is exported for that purpose), so a push into
// a full buffer without a simultaneous pop never happens.
module fft_rd_skid
    import fft_rd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;
    logic             pop;

    assign pop       = (occ_q != 2'd0) & pop_ready;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = head_q;
    assign occ       = occ_q;

    // Next-state of the two entries: head is always the oldest word.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case (occ_q)
            2'd0: begin
                if (push) begin
                    head_d = push_data;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                case ({push, pop})
                    2'b11: head_d = push_data;
                    2'b10: begin
                        tail_d = push_data;
                        occ_d  = 2'd2;
                    end
                    2'b01: occ_d = 2'd0;
                    default: ;
                endcase
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = 2'd1;
                    if (push) begin
                        tail_d = push_data;
                        occ_d  = 2'd2;
                    end
                end
            end
            default: occ_d = 2'd0;
        endcase
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data entries are reset too so the presented fields read 0, not X, after reset.
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values; comb blocks use =.
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: rtl/fft_modulus_fifo_rd.sv
// Read-side engine of the FFT modulus FIFO. Pops 73-bit words, checks the
// frame framing (sof on index 0, contiguous indices), scales the modulus to
// the display magnitude and streams bins out through a 2-entry skid buffer.
// Optional peak tracker: define FFT_RD_PEAK_EN to add peak_mag/peak_index/
// peak_valid; without it the block has no peak ports or logic.
module fft_modulus_fifo_rd
    import fft_rd_pkg::*;
#(
    parameter int IDX_WIDTH  = DEF_IDX_WIDTH,
    parameter int MOD_WIDTH  = DEF_MOD_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,   // must equal 1+IDX_WIDTH+MOD_WIDTH
    parameter int MAG_WIDTH  = DEF_MAG_WIDTH,
    parameter int MAG_SHIFT  = DEF_MAG_SHIFT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [MAG_WIDTH-1:0]  m_mag,
    output logic [IDX_WIDTH-1:0]  m_index,
    output logic                  m_sof,
    output logic                  m_last,
    output logic                  frame_done,
    output logic                  sync_err,
    output logic [15:0]           frame_cnt
`ifdef FFT_RD_PEAK_EN
    ,
    output logic [MAG_WIDTH-1:0]  peak_mag,
    output logic [IDX_WIDTH-1:0]  peak_index,
    output logic                  peak_valid
`endif
);

    localparam int SOF_POS = DATA_WIDTH - 1;
    localparam int IDX_POS = MOD_WIDTH;
    localparam int ENTRY_W = 2 + IDX_WIDTH + MAG_WIDTH;

    localparam logic [IDX_WIDTH-1:0] IDX_ZERO = '0;
    localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = {IDX_WIDTH{1'b1}};

    // ------------------------------------------------------------------
    // Read issue: keep skid occupancy plus the word in flight at most 2.
    // ------------------------------------------------------------------
    logic       inflight_q;
    logic [1:0] occ;
    logic       pop;
    logic [2:0] budget;

    assign pop        = m_valid & m_ready;
    assign budget     = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    assign fifo_rd_en = enable & ~fifo_rd_empty & (budget < 3'd2);

    // The FIFO has no output register: data for a strobe arrives next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight_q <= 1'b0;
        else        inflight_q <= fifo_rd_en;
    end

    // ------------------------------------------------------------------
    // Word classification.
    // ------------------------------------------------------------------
    logic                 w_sof;
    logic [IDX_WIDTH-1:0] w_idx;
    logic [MOD_WIDTH-1:0] w_mod;
    logic                 is_first;
    logic                 in_seq;

    rd_state_t            state_q, state_d;
    logic [IDX_WIDTH-1:0] exp_idx_q, exp_idx_d;

    assign w_sof    = fifo_rd_data[SOF_POS];
    assign w_idx    = fifo_rd_data[IDX_POS +: IDX_WIDTH];
    assign w_mod    = fifo_rd_data[MOD_WIDTH-1:0];
    assign is_first = w_sof & (w_idx == IDX_ZERO);
    // Expected word: sof set exactly when the expected index is 0.
    assign in_seq   = (w_sof == (exp_idx_q == IDX_ZERO)) & (w_idx == exp_idx_q);

    // ------------------------------------------------------------------
    // Framing FSM.
    // ------------------------------------------------------------------
    logic push_c;
    logic err_c;

    // State register with the expected-index tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SYNC;
            exp_idx_q <= IDX_ZERO;
        end else begin
            state_q   <= state_d;
            exp_idx_q <= exp_idx_d;
        end
    end

    // Next-state logic: expected index wraps naturally after the last bin.
    always_comb begin
        state_d   = state_q;
        exp_idx_d = exp_idx_q;
        case (state_q)
            SYNC: begin
                if (inflight_q && is_first) begin
                    state_d   = RUN;
                    exp_idx_d = IDX_ONE;
                end
            end
            RUN: begin
                if (inflight_q) begin
                    if (in_seq) begin
                        exp_idx_d = exp_idx_q + IDX_ONE;
                    end else if (is_first) begin
                        exp_idx_d = IDX_ONE;
                    end else begin
                        state_d   = SYNC;
                        exp_idx_d = IDX_ZERO;
                    end
                end else if (!enable) begin
                    // Reads stopped and nothing left in flight: resync on restart.
                    state_d   = SYNC;
                    exp_idx_d = IDX_ZERO;
                end
            end
            default: begin
                state_d   = SYNC;
                exp_idx_d = IDX_ZERO;
            end
        endcase
    end

    // Output logic: which returned words enter the skid, which are errors.
    always_comb begin
        push_c = 1'b0;
        err_c  = 1'b0;
        case (state_q)
            SYNC: push_c = inflight_q & is_first;
            RUN: begin
                if (inflight_q) begin
                    push_c = in_seq | is_first;
                    err_c  = ~in_seq;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Scaling and skid buffer.
    // ------------------------------------------------------------------
    logic [MAG_WIDTH-1:0] push_mag;
    logic [ENTRY_W-1:0]   push_entry;
    logic [ENTRY_W-1:0]   skid_out;

    assign push_mag   = MAG_WIDTH'(sat_shift(SAT_IN_W'(w_mod), MAG_SHIFT, MAG_WIDTH));
    assign push_entry = {w_sof, (w_idx == IDX_LAST), w_idx, push_mag};

    fft_rd_skid #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .push_data (push_entry),
        .pop_ready (m_ready),
        .out_valid (m_valid),
        .out_data  (skid_out),
        .occ       (occ)
    );

    assign {m_sof, m_last, m_index, m_mag} = skid_out;

    // Frame completion and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            frame_done <= pop & m_last;
            sync_err   <= err_c;
            if (pop && m_last) frame_cnt <= frame_cnt + 16'd1;
        end
    end

`ifdef FFT_RD_PEAK_EN
    // ------------------------------------------------------------------
    // Peak tracker over accepted beats of the current frame.
    // ------------------------------------------------------------------
    logic [MAG_WIDTH-1:0] trk_mag_q, cand_mag;
    logic [IDX_WIDTH-1:0] trk_idx_q, cand_idx;

    // Candidate peak: cleared by a framing error, restarted by the sof beat;
    // strict '>' keeps the earlier (lower) index on ties.
    always_comb begin
        cand_mag = err_c ? '0 : trk_mag_q;
        cand_idx = err_c ? '0 : trk_idx_q;
        if (pop && (m_sof || (m_mag > cand_mag))) begin
            cand_mag = m_mag;
            cand_idx = m_index;
        end
    end

    // Tracker and published peak registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_mag_q  <= '0;
            trk_idx_q  <= '0;
            peak_mag   <= '0;
            peak_index <= '0;
            peak_valid <= 1'b0;
        end else begin
            trk_mag_q  <= cand_mag;
            trk_idx_q  <= cand_idx;
            peak_valid <= pop & m_last;
            if (pop && m_last) begin
                peak_mag   <= cand_mag;
                peak_index <= cand_idx;
            end
        end
    end
`else
    // Peak tracking not built: no extra ports or state.
`endif

endmodule

// File: tb/tb_fft_modulus_fifo_rd.sv
// Directed bench for fft_modulus_fifo_rd: a behavioural FIFO feeds framed
// words, a scoreboard holds the hand-derived beats each word must produce.
module tb_fft_modulus_fifo_rd;
    import fft_rd_pkg::*;

    localparam int IW        = 11;
    localparam int MW        = 61;
    localparam int DW        = 73;
    localparam int GW        = 16;
    localparam int FRAME     = 2048;
    localparam int MEM_DEPTH = 8192;

    typedef logic [1+1+IW+GW-1:0] beat_t;   // {sof, last, index, mag}

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_empty;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [GW-1:0] m_mag;
    logic [IW-1:0] m_index;
    logic          m_sof;
    logic          m_last;
    logic          frame_done;
    logic          sync_err;
    logic [15:0]   frame_cnt;
`ifdef FFT_RD_PEAK_EN
    logic [GW-1:0] peak_mag;
    logic [IW-1:0] peak_index;
    logic          peak_valid;
    logic [GW-1:0] last_pk_mag = '0;
    logic [IW-1:0] last_pk_idx = '0;
`endif

    fft_modulus_fifo_rd u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_mag         (m_mag),
        .m_index       (m_index),
        .m_sof         (m_sof),
        .m_last        (m_last),
        .frame_done    (frame_done),
        .sync_err      (sync_err),
        .frame_cnt     (frame_cnt)
`ifdef FFT_RD_PEAK_EN
        ,
        .peak_mag      (peak_mag),
        .peak_index    (peak_index),
        .peak_valid    (peak_valid)
`endif
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    beat_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- FIFO model (no output register) ----------------
    logic [DW-1:0] mem [MEM_DEPTH];
    int wr_ptr  = 0;
    int rd_ptr  = 0;
    int rd_viol = 0;

    assign fifo_rd_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (rd_ptr == wr_ptr) begin
                rd_viol <= rd_viol + 1;
            end else begin
                fifo_rd_data <= mem[rd_ptr % MEM_DEPTH];
                rd_ptr       <= rd_ptr + 1;
            end
        end
    end

    // ---------------- Sink / monitor ----------------
    int    ready_mode  = 0;
    bit    prev_stall  = 1'b0;
    beat_t prev_beat   = '0;
    int    first_valid = -1;
    int    first_acc   = -1;
    int    last_acc    = -1;
    int    done_cnt    = 0;
    int    err_cnt     = 0;

    always @(negedge clk) begin
        beat_t got;
        m_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        got = {m_sof, m_last, m_index, m_mag};
        if (prev_stall)
            check("hold", 64'({m_valid, got}), 64'({1'b1, prev_beat}));
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (m_valid && m_ready) begin
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            if (exp_q.size() == 0) check("extra_beat", 64'(got), 64'(0));
            else                   check("beat", 64'(got), 64'(exp_q.pop_front()));
        end
        prev_stall = m_valid && !m_ready;
        prev_beat  = got;
        if (frame_done) done_cnt++;
        if (sync_err)   err_cnt++;
`ifdef FFT_RD_PEAK_EN
        if (frame_done || peak_valid)
            check("peak_with_done", 64'(peak_valid), 64'(frame_done));
        if (peak_valid) begin
            last_pk_mag = peak_mag;
            last_pk_idx = peak_index;
        end
`endif
    end

    // ---------------- Stimulus helpers ----------------
    task automatic push_word(input logic sof, input int idx, input logic [MW-1:0] modv,
                             input logic [GW-1:0] mag, input bit pass);
        mem[wr_ptr % MEM_DEPTH] = {sof, IW'(idx), modv};
        wr_ptr++;
        if (pass) exp_q.push_back({sof, (idx == FRAME - 1), IW'(idx), mag});
    endtask

    // kind 0: modulus = idx<<24; kind 1: peak pattern; kind 2: saturation corners.
    // skip >= 0 omits that index; later words of the frame are expected dropped.
    task automatic load_frame(input int kind, input int skip);
        for (int i = 0; i < FRAME; i++) begin
            logic [MW-1:0] modv;
            logic [GW-1:0] mag;
            mag  = GW'(i);
            modv = MW'(i) << 24;
            if (kind == 1) begin
                mag  = (i == 300 || i == 900) ? GW'(7) : GW'(i % 7);
                modv = (MW'(mag) << 24) | MW'(i);
            end else if (kind == 2) begin
                case (i)
                    0: begin modv = (MW'(1) << 60) - MW'(1);               mag = 16'hFFFF; end
                    1: begin modv = (MW'(16'h1234) << 24) + MW'(5);        mag = 16'h1234; end
                    2: begin modv = (MW'(16'hFFFF) << 24) | MW'(24'hFFFFFF); mag = 16'hFFFF; end
                    3: begin modv = MW'(1) << 40;                           mag = 16'hFFFF; end
                    4: begin modv = MW'(1) << 60;                           mag = 16'hFFFF; end
                    default: ;
                endcase
            end
            if (i != skip)
                push_word(i == 0, i, modv, mag, (skip < 0) || (i < skip));
        end
    endtask

    task automatic start_stream();
        @(negedge clk);
        first_valid = -1;
        first_acc   = -1;
        last_acc    = -1;
        enable      = 1'b1;
    endtask

    task automatic stop_stream();
        enable = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        int n = 0;
        while ((rd_ptr != wr_ptr || exp_q.size() != 0) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 64'(n >= max_cycles), 64'(0));
        repeat (4) @(negedge clk);
    endtask

    // ---------------- Test sequence ----------------
    initial begin
        int en_cyc;
        repeat (3) @(negedge clk);
        check("rst_m_valid",    64'(m_valid),    64'(0));
        check("rst_rd_en",      64'(fifo_rd_en), 64'(0));
        check("rst_frame_cnt",  64'(frame_cnt),  64'(0));
        check("rst_frame_done", 64'(frame_done), 64'(0));
        check("rst_sync_err",   64'(sync_err),   64'(0));
        check("rst_fields",     64'({m_sof, m_last, m_index, m_mag}), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean stream, full throughput.
        load_frame(0, -1);
        start_stream();
        en_cyc = cyc;
        wait_drain("clean", 5000);
        check("clean_latency",   64'(first_valid - en_cyc), 64'(2));
        check("clean_span",      64'(last_acc - first_acc), 64'(FRAME - 1));
        check("clean_frame_cnt", 64'(frame_cnt), 64'(1));
        check("clean_done_cnt",  64'(done_cnt),  64'(1));
        check("clean_err_cnt",   64'(err_cnt),   64'(0));
        stop_stream();

        // Back-pressure: ready one cycle in three.
        ready_mode = 1;
        load_frame(0, -1);
        start_stream();
        wait_drain("bp", 10000);
        ready_mode = 0;
        check("bp_frame_cnt", 64'(frame_cnt), 64'(2));
        check("bp_done_cnt",  64'(done_cnt),  64'(2));
        check("bp_err_cnt",   64'(err_cnt),   64'(0));
        stop_stream();

        // Resync: junk without sof is dropped silently, then a peak frame.
        for (int i = 0; i < 5; i++) push_word(1'b0, 10 + i, MW'(i) << 24, '0, 1'b0);
        load_frame(1, -1);
        start_stream();
        wait_drain("resync", 5000);
        check("resync_err_cnt",   64'(err_cnt),   64'(0));
        check("resync_frame_cnt", 64'(frame_cnt), 64'(3));
`ifdef FFT_RD_PEAK_EN
        check("peak_mag",   64'(last_pk_mag), 64'(7));
        check("peak_index", 64'(last_pk_idx), 64'(300));
`endif
        stop_stream();

        // Mid-frame error: index 101 missing, then a clean frame.
        load_frame(0, 101);
        load_frame(0, -1);
        start_stream();
        wait_drain("skip", 10000);
        check("skip_err_cnt",   64'(err_cnt),   64'(1));
        check("skip_frame_cnt", 64'(frame_cnt), 64'(4));
        check("skip_done_cnt",  64'(done_cnt),  64'(4));
        stop_stream();

        // Saturation corners.
        load_frame(2, -1);
        start_stream();
        wait_drain("sat", 5000);
        check("sat_frame_cnt", 64'(frame_cnt), 64'(5));
        stop_stream();

        // Reset mid-frame, then residual words resync onto a new frame.
        load_frame(0, -1);
        start_stream();
        repeat (50) @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midrst_m_valid",   64'(m_valid),   64'(0));
        check("midrst_frame_cnt", 64'(frame_cnt), 64'(0));
        check("midrst_rd_en",     64'(fifo_rd_en), 64'(0));
        exp_q.delete();
        prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load_frame(0, -1);
        start_stream();
        wait_drain("midrst", 10000);
        check("midrst_frame_cnt2", 64'(frame_cnt), 64'(1));
        check("midrst_err_cnt",    64'(err_cnt),   64'(1));
        check("midrst_done_cnt",   64'(done_cnt),  64'(6));
        stop_stream();

        check("rd_while_empty", 64'(rd_viol), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
